mem_arbiter_2p: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 4K x 4 banked memory block (`mem_block`: four 1K x 4 synchronous BRAMs, bank chosen by addr[11:10], output mux driven combinationally by the live address). It grants one read or write per arbitration cycle and registers the memory command. It holds the address stable through the BRAM read cycle so the bank output mux selects the correct bank. It returns read data to the issuing requester with a fixed latency.

---
 rtl/mem_arbiter_2p.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter_2p.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2p.sv
// Two-requester round-robin arbiter and command sequencer for the banked 4K x 4 memory block.
// Reads hold mem_addr through the BRAM output cycle so the block's bank mux stays valid.
//
// state   | meaning
// --------+------------------------------------------------------------
// ARB     | grants allowed; a granted write stays here, a granted read leaves
// RD_WAIT | BRAM is sampling the read address; no grant for exactly one cycle
module mem_arbiter_2p #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   typedef enum logic {
      ARB     = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    last_q, last_d;
   logic                    grant;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_din;

   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;

   // Read return pipeline: stage 1 = address presented, stage 2 = mem_dout valid.
   logic                    rd_p1_q, rd_p1_d;
   logic                    own_p1_q, own_p1_d;
   logic                    rd_p2_q;
   logic                    own_p2_q;
   logic                    rvalid0_q, rvalid1_q;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (grant && !sel_we) state_d = RD_WAIT;
         RD_WAIT: state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // Grants are gated by reset_n so nothing is offered while the block is held in reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n && (state_q == ARB)) begin
         if (req0 && (!req1 || last_q)) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign grant    = gnt0 | gnt1;
   assign sel_we   = gnt1 ? we1   : we0;
   assign sel_addr = gnt1 ? addr1 : addr0;
   assign sel_din  = gnt1 ? din1  : din0;

   always_comb begin
      last_d     = last_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      rd_p1_d    = 1'b0;
      own_p1_d   = own_p1_q;
      if (grant) begin
         last_d     = gnt1;
         mem_we_d   = sel_we;
         mem_addr_d = sel_addr;
         mem_din_d  = sel_din;
         rd_p1_d    = !sel_we;
         own_p1_d   = gnt1;
      end
   end

   assign rdata_d = rd_p2_q ? mem_dout : rdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q     <= 1'b1;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rd_p1_q    <= 1'b0;
         own_p1_q   <= 1'b0;
         rd_p2_q    <= 1'b0;
         own_p2_q   <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         last_q     <= last_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rd_p1_q    <= rd_p1_d;
         own_p1_q   <= own_p1_d;
         rd_p2_q    <= rd_p1_q;
         own_p2_q   <= own_p1_q;
         rvalid0_q  <= rd_p2_q & ~own_p2_q;
         rvalid1_q  <= rd_p2_q &  own_p2_q;
         rdata_q    <= rdata_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a behavioural model of the four-bank memory block
// (per-bank synchronous read, output mux driven by the live mem_addr).
module tb_mem_arbiter_2p;

   logic        clk;
   logic        reset_n;
   logic        req0, req1;
   logic        we0, we1;
   logic [11:0] addr0, addr1;
   logic [3:0]  din0, din1;
   logic        gnt0, gnt1;
   logic        rvalid0, rvalid1;
   logic [3:0]  rdata;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [3:0]  mem_din;
   logic [3:0]  mem_dout;

   int checks = 0;
   int errors = 0;

   mem_arbiter_2p #(.ADDR_WIDTH(12), .DATA_WIDTH(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .din0     (din0),
      .din1     (din1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1),
      .rdata    (rdata),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory block model: each bank registers its own word, the mux follows mem_addr live.
   logic [3:0] mem_arr [0:4095];
   logic [3:0] bank_q  [0:3];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         bank_q[b] <= mem_arr[{2'(b), mem_addr[9:0]}];
      end
      if (mem_we) mem_arr[mem_addr] <= mem_din;
   end

   assign mem_dout = bank_q[mem_addr[11:10]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w, input logic [11:0] a, input logic [3:0] d);
      req0 = r; we0 = w; addr0 = a; din0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [11:0] a, input logic [3:0] d);
      req1 = r; we1 = w; addr1 = a; din1 = d;
   endtask

   initial begin
      reset_n = 1'b0;
      set0(1'b1, 1'b1, 12'h005, 4'hA);
      set1(1'b1, 1'b1, 12'hC10, 4'h3);

      // Reset held with both requests pending.
      tick();
      tick();
      settle();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);

      // C0: release, requester 0 wins the first tie.
      tick();
      reset_n = 1'b1;
      settle();
      chk("c0_gnt0", gnt0, 1);
      chk("c0_gnt1", gnt1, 0);

      // C1: requester 1 write still pending; previous write on the memory bus.
      tick();
      set0(1'b0, 1'b0, 12'h000, 4'h0);
      settle();
      chk("c1_gnt1", gnt1, 1);
      chk("c1_mem_we", mem_we, 1);
      chk("c1_mem_addr", mem_addr, 12'h005);
      chk("c1_mem_din", mem_din, 4'hA);

      // C2: requester 0 writes 0x7 to 0x010.
      tick();
      set1(1'b0, 1'b0, 12'h000, 4'h0);
      set0(1'b1, 1'b1, 12'h010, 4'h7);
      settle();
      chk("c2_gnt0", gnt0, 1);
      chk("c2_mem_addr", mem_addr, 12'hC10);
      chk("c2_mem_din", mem_din, 4'h3);

      // C3: requester 0 reads 0x005.
      tick();
      set0(1'b1, 1'b0, 12'h005, 4'h0);
      settle();
      chk("c3_gnt0_read", gnt0, 1);
      chk("c3_mem_addr", mem_addr, 12'h010);

      // C4: RD_WAIT, both queue reads, nobody granted.
      tick();
      set0(1'b1, 1'b0, 12'h010, 4'h0);
      set1(1'b1, 1'b0, 12'hC10, 4'h0);
      settle();
      chk("c4_gnt0_wait", gnt0, 0);
      chk("c4_gnt1_wait", gnt1, 0);
      chk("c4_mem_we", mem_we, 0);
      chk("c4_mem_addr", mem_addr, 12'h005);

      // C5: requester 1 wins the tie; address still held while mem_dout is valid.
      tick();
      settle();
      chk("c5_gnt1", gnt1, 1);
      chk("c5_gnt0", gnt0, 0);
      chk("c5_mem_addr_hold", mem_addr, 12'h005);
      chk("c5_rvalid0", rvalid0, 0);

      // C6: first read returns; arbiter waits for requester 1's read.
      tick();
      set1(1'b0, 1'b0, 12'h000, 4'h0);
      settle();
      chk("c6_rvalid0", rvalid0, 1);
      chk("c6_rdata", rdata, 4'hA);
      chk("c6_gnt0_wait", gnt0, 0);
      chk("c6_mem_addr", mem_addr, 12'hC10);

      // C7: requester 0 granted; 0xC10 still on the bus for the bank mux.
      tick();
      settle();
      chk("c7_gnt0", gnt0, 1);
      chk("c7_mem_addr_hold", mem_addr, 12'hC10);
      chk("c7_rvalid0", rvalid0, 0);

      // C8: bank 3 data returned to requester 1.
      tick();
      set0(1'b0, 1'b0, 12'h000, 4'h0);
      settle();
      chk("c8_rvalid1", rvalid1, 1);
      chk("c8_rvalid0", rvalid0, 0);
      chk("c8_rdata", rdata, 4'h3);
      chk("c8_mem_addr", mem_addr, 12'h010);

      // C9: rdata holds between returns.
      tick();
      settle();
      chk("c9_rvalid1", rvalid1, 0);
      chk("c9_rdata_hold", rdata, 4'h3);

      // C10: bank 0 data returned to requester 0.
      tick();
      settle();
      chk("c10_rvalid0", rvalid0, 1);
      chk("c10_rdata", rdata, 4'h7);

      // Round-robin with continuous writes: requester 0 was granted last, so 1 goes first.
      set0(1'b1, 1'b1, 12'h100, 4'h1);
      set1(1'b1, 1'b1, 12'h200, 4'h2);
      settle();
      chk("rr0_gnt1", gnt1, 1);
      chk("rr0_gnt0", gnt0, 0);
      tick();
      settle();
      chk("rr1_gnt0", gnt0, 1);
      chk("rr1_gnt1", gnt1, 0);
      chk("rr1_mem_addr", mem_addr, 12'h200);
      tick();
      settle();
      chk("rr2_gnt1", gnt1, 1);
      chk("rr2_gnt0", gnt0, 0);
      chk("rr2_mem_addr", mem_addr, 12'h100);
      tick();
      settle();
      chk("rr3_gnt0", gnt0, 1);
      chk("rr3_gnt1", gnt1, 0);
      chk("rr3_mem_we", mem_we, 1);

      // Read-after-write at bank 3 top address.
      tick();
      set0(1'b0, 1'b0, 12'h000, 4'h0);
      set1(1'b1, 1'b1, 12'hFFF, 4'hF);
      settle();
      chk("raw0_gnt1", gnt1, 1);
      tick();
      set1(1'b1, 1'b0, 12'hFFF, 4'h0);
      settle();
      chk("raw1_gnt1_read", gnt1, 1);
      chk("raw1_mem_we", mem_we, 1);
      chk("raw1_mem_addr", mem_addr, 12'hFFF);
      tick();
      set1(1'b0, 1'b0, 12'h000, 4'h0);
      settle();
      chk("raw2_mem_we", mem_we, 0);
      tick();
      settle();
      chk("raw3_rvalid1", rvalid1, 0);
      tick();
      settle();
      chk("raw4_rvalid1", rvalid1, 1);
      chk("raw4_rdata", rdata, 4'hF);

      // Reset mid-read: pulse reset in the cycle after the read grant.
      tick();
      set0(1'b1, 1'b0, 12'h005, 4'h0);
      settle();
      chk("mr0_gnt0", gnt0, 1);
      tick();
      set0(1'b0, 1'b0, 12'h000, 4'h0);
      reset_n = 1'b0;
      settle();
      chk("mr1_gnt0", gnt0, 0);
      chk("mr1_mem_addr", mem_addr, 0);
      chk("mr1_rdata", rdata, 0);
      reset_n = 1'b1;
      // First cycle after reset: ARB with pointer back at requester 1, no stale write enable.
      tick();
      set0(1'b1, 1'b1, 12'h020, 4'h5);
      set1(1'b1, 1'b1, 12'h030, 4'h6);
      settle();
      chk("mr2_gnt0", gnt0, 1);
      chk("mr2_gnt1", gnt1, 0);
      chk("mr2_mem_we", mem_we, 0);
      chk("mr2_rvalid0", rvalid0, 0);
      tick();
      set0(1'b0, 1'b0, 12'h000, 4'h0);
      set1(1'b0, 1'b0, 12'h000, 4'h0);
      settle();
      chk("mr3_rvalid0", rvalid0, 0);
      chk("mr3_mem_we", mem_we, 1);
      chk("mr3_mem_addr", mem_addr, 12'h020);
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("mr_no_rvalid0", rvalid0, 0);
         chk("mr_no_rvalid1", rvalid1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
